// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among NREQ byte requesters,
// with packet locking (req_last), optional inter-frame gap and done watchdog.
module uart_tx_sched #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned DONE_TMO   = 0,
    localparam int unsigned IDW       = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    output logic [7:0]           tx_d_in,
    output logic                 tx_en,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic [IDW-1:0]       grant_id,
    output logic                 active,
    output logic                 locked,
    output logic [15:0]          frame_cnt,
    output logic                 tmo_err
);

    localparam int unsigned GAPW = 16;
    localparam int unsigned TMOW = 32;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_DONE = 2'd1;
    localparam logic [1:0] S_GAP       = 2'd2;

    logic [1:0]      state, state_d;
    logic [IDW-1:0]  rr_ptr, rr_ptr_d;
    logic [GAPW-1:0] gap_cnt, gap_cnt_d;
    logic [TMOW-1:0] tmo_cnt, tmo_cnt_d;

    logic [NREQ-1:0] req_ready_d;
    logic [7:0]      tx_d_in_d;
    logic            tx_en_d;
    logic [IDW-1:0]  grant_id_d;
    logic            active_d;
    logic            locked_d;
    logic [15:0]     frame_cnt_d;
    logic            tmo_err_d;

    logic [NREQ-1:0] elig_c;
    logic [IDW-1:0]  idx_c;
    logic [IDW-1:0]  win_c;
    logic            found_c;
    logic [7:0]      win_byte_c;

    // A held packet lock restricts eligibility to the current owner
    always_comb begin
        elig_c = locked ? (req_valid & (NREQ'(1) << grant_id)) : req_valid;
    end

    // Round-robin search starting just after the last winner
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        idx_c   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx_c = IDW'((32'(rr_ptr) + k) % NREQ);
            if (!found_c && elig_c[idx_c]) begin
                found_c = 1'b1;
                win_c   = idx_c;
            end
        end
        win_byte_c = req_data[{win_c, 3'b000} +: 8];
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        gap_cnt_d   = gap_cnt;
        tmo_cnt_d   = tmo_cnt;
        req_ready_d = '0;
        tx_d_in_d   = tx_d_in;
        tx_en_d     = 1'b0;
        grant_id_d  = grant_id;
        active_d    = active;
        locked_d    = locked;
        frame_cnt_d = frame_cnt;
        tmo_err_d   = 1'b0;

        case (state)
            S_IDLE: begin
                if (!tx_busy && found_c) begin
                    tx_d_in_d   = win_byte_c;
                    grant_id_d  = win_c;
                    rr_ptr_d    = win_c;
                    locked_d    = ~req_last[win_c];
                    req_ready_d = NREQ'(1) << win_c;
                    tx_en_d     = 1'b1;
                    active_d    = 1'b1;
                    tmo_cnt_d   = '0;
                    state_d     = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    frame_cnt_d = frame_cnt + 16'd1;
                    active_d    = 1'b0;
                    gap_cnt_d   = '0;
                    state_d     = (GAP_CYCLES != 0) ? S_GAP : S_IDLE;
                end else if ((DONE_TMO != 0) && (tmo_cnt == TMOW'(DONE_TMO - 1))) begin
                    tmo_err_d = 1'b1;
                    locked_d  = 1'b0;
                    active_d  = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt + TMOW'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt == GAPW'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt + GAPW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= IDW'(NREQ - 1);
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
            req_ready <= '0;
            tx_d_in   <= '0;
            tx_en     <= 1'b0;
            grant_id  <= '0;
            active    <= 1'b0;
            locked    <= 1'b0;
            frame_cnt <= '0;
            tmo_err   <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            gap_cnt   <= gap_cnt_d;
            tmo_cnt   <= tmo_cnt_d;
            req_ready <= req_ready_d;
            tx_d_in   <= tx_d_in_d;
            tx_en     <= tx_en_d;
            grant_id  <= grant_id_d;
            active    <= active_d;
            locked    <= locked_d;
            frame_cnt <= frame_cnt_d;
            tmo_err   <= tmo_err_d;
        end
    end

endmodule
